// File: rtl/uart_rx_param.sv
// Parametrised UART receiver. The line is oversampled, each bit is decided by a
// 2-of-3 vote around mid-bit, and words are handed off on a valid/ready port.
// The block also reports parity, frame, overrun and break conditions.
module uart_rx_param #(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clk_en,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 break_det,
  output logic                 busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam int M  = OVERSAMPLE / 2;

  localparam logic [TW-1:0] T_S0   = TW'(M - 1);
  localparam logic [TW-1:0] T_S1   = TW'(M);
  localparam logic [TW-1:0] T_DEC  = TW'(M + 1);
  localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_DLAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] B_SLAST = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {S_ARM, S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [SYNC_STAGES-1:0] r_flush;
  logic [TW-1:0]          r_tick;
  logic [BW-1:0]          r_bit;
  logic                   r_s0, r_s1;
  logic [DATA_BITS-1:0]   r_shift;
  logic                   r_par;
  logic                   r_stop1;
  logic                   r_ferr;
  logic                   r_done;
  logic                   r_brk;
  logic                   r_busy;

  logic [DATA_BITS-1:0]   r_data;
  logic                   r_valid, r_perr_q, r_ferr_q, r_ovr, r_brk_q;

  logic w_rxs, w_flushed, w_maj, w_perr, w_ferr_fin, w_stop1_now, w_brk_now;

  assign w_rxs     = r_sync[SYNC_STAGES-1];
  // The synchroniser resets to 1, so it only reflects the pin once refilled;
  // ARM waits for that so a line held low through reset never looks idle.
  assign w_flushed = r_flush[SYNC_STAGES-1];
  assign w_maj     = (r_s0 & r_s1) | (r_s0 & w_rxs) | (r_s1 & w_rxs);

  assign w_ferr_fin  = (r_bit == '0) ? ~w_maj : (r_ferr | ~w_maj);
  assign w_stop1_now = (r_bit == '0) ? w_maj : r_stop1;
  assign w_brk_now   = (r_shift == '0) && ((PARITY == 0) || !r_par) && !w_stop1_now;

  // Parity check over the completed word, read in the cycle after completion
  always_comb begin
    w_perr = 1'b0;
    if (PARITY == 1)      w_perr = ~(^r_shift ^ r_par);
    else if (PARITY == 2) w_perr = ^r_shift ^ r_par;
  end

  // Input synchroniser and its refill tracker, every clk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync  <= '1;
      r_flush <= '0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], rx};
      r_flush <= {r_flush[SYNC_STAGES-2:0], 1'b1};
    end
  end

  // Receive FSM; advances only on oversample ticks
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_ARM;
      r_tick  <= '0;
      r_bit   <= '0;
      r_s0    <= 1'b0;
      r_s1    <= 1'b0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_stop1 <= 1'b0;
      r_ferr  <= 1'b0;
      r_done  <= 1'b0;
      r_brk   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_brk  <= 1'b0;
      if (clk_en) begin
        case (r_state)
          S_ARM: begin
            if (w_flushed && w_rxs) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_busy  <= 1'b1;
            end
          end
          S_IDLE: begin
            // this tick is t=0 of the start bit
            if (!w_rxs) begin
              r_state <= S_START;
              r_tick  <= TW'(1);
              r_busy  <= 1'b1;
            end
          end
          default: begin
            if (r_tick == T_S0) r_s0 <= w_rxs;
            if (r_tick == T_S1) r_s1 <= w_rxs;
            r_tick <= (r_tick == T_LAST) ? '0 : r_tick + 1'b1;
            case (r_state)
              S_START: begin
                if (r_tick == T_DEC && w_maj) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
                end else if (r_tick == T_LAST) begin
                  r_state <= S_DATA;
                  r_bit   <= '0;
                end
              end
              S_DATA: begin
                if (r_tick == T_DEC) r_shift <= {w_maj, r_shift[DATA_BITS-1:1]};
                if (r_tick == T_LAST) begin
                  if (r_bit == B_DLAST) begin
                    r_bit   <= '0;
                    r_state <= (PARITY != 0) ? S_PAR : S_STOP;
                  end else begin
                    r_bit   <= r_bit + 1'b1;
                  end
                end
              end
              S_PAR: begin
                if (r_tick == T_DEC) r_par <= w_maj;
                if (r_tick == T_LAST) begin
                  r_state <= S_STOP;
                  r_bit   <= '0;
                end
              end
              S_STOP: begin
                if (r_tick == T_DEC) begin
                  r_ferr <= w_ferr_fin;
                  if (r_bit == '0) r_stop1 <= w_maj;
                  // last stop decision completes the frame without waiting for bit end
                  if (r_bit == B_SLAST) begin
                    r_done  <= 1'b1;
                    r_brk   <= w_brk_now;
                    r_tick  <= '0;
                    r_bit   <= '0;
                    r_state <= w_brk_now ? S_ARM : S_IDLE;
                    r_busy  <= w_brk_now;
                  end
                end else if (r_tick == T_LAST) begin
                  r_bit <= r_bit + 1'b1;
                end
              end
              default: r_state <= S_ARM;
            endcase
          end
        endcase
      end
    end
  end

  // Completion and valid/ready handoff, every clk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_perr_q <= 1'b0;
      r_ferr_q <= 1'b0;
      r_ovr    <= 1'b0;
      r_brk_q  <= 1'b0;
    end else begin
      r_ovr   <= 1'b0;
      r_brk_q <= 1'b0;
      if (r_valid && rx_ready) begin
        r_valid  <= 1'b0;
        r_perr_q <= 1'b0;
        r_ferr_q <= 1'b0;
      end
      if (r_done) begin
        if (r_brk) begin
          r_brk_q <= 1'b1;
        end else if (!r_valid || rx_ready) begin
          r_data   <= r_shift;
          r_perr_q <= w_perr;
          r_ferr_q <= r_ferr;
          r_valid  <= 1'b1;
        end else begin
          r_ovr    <= 1'b1;
        end
      end
    end
  end

  assign rx_data    = r_data;
  assign rx_valid   = r_valid;
  assign parity_err = r_perr_q;
  assign frame_err  = r_ferr_q;
  assign overrun    = r_ovr;
  assign break_det  = r_brk_q;
  assign busy       = r_busy;

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: an 8N1 instance and an even-parity instance, each
// on its own line. Words the bench sends are predicted from the frame rules
// (parity by bit count, stop value, break pattern) and compared to what the
// consumer side accepts.
module tb_uart_rx_param;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_a = 1'b1, rx_p = 1'b1;
  logic       rdy_a = 1'b1, rdy_p = 1'b1;

  logic [7:0] a_data, p_data;
  logic       a_valid, a_pe, a_fe, a_ovr, a_brk, a_busy;
  logic       p_valid, p_pe, p_fe, p_ovr, p_brk, p_busy;

  int checks = 0;
  int failures = 0;

  logic [9:0] got_a[$];
  logic [9:0] got_p[$];
  int ovr_a = 0, brk_a = 0, ovr_p = 0, brk_p = 0;

  always #10 clk = ~clk;

  uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(0), .STOP_BITS(1), .SYNC_STAGES(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .clk_en(1'b1), .rx(rx_a),
    .rx_data(a_data), .rx_valid(a_valid), .rx_ready(rdy_a),
    .parity_err(a_pe), .frame_err(a_fe), .overrun(a_ovr), .break_det(a_brk), .busy(a_busy)
  );

  uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(2), .STOP_BITS(1), .SYNC_STAGES(2)) u_dut_p (
    .clk(clk), .rst_n(rst_n), .clk_en(1'b1), .rx(rx_p),
    .rx_data(p_data), .rx_valid(p_valid), .rx_ready(rdy_p),
    .parity_err(p_pe), .frame_err(p_fe), .overrun(p_ovr), .break_det(p_brk), .busy(p_busy)
  );

  // consumer side: record accepted words {perr, ferr, data} and pulse counts
  always @(negedge clk) begin
    if (rst_n) begin
      if (a_valid && rdy_a) got_a.push_back({a_pe, a_fe, a_data});
      if (p_valid && rdy_p) got_p.push_back({p_pe, p_fe, p_data});
      if (a_ovr) ovr_a++;
      if (a_brk) brk_a++;
      if (p_ovr) ovr_p++;
      if (p_brk) brk_p++;
    end
  end

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // one bit period (16 clk) on the chosen line; starts and ends at posedge+2
  task automatic drive_bit(input bit p, input logic v);
    if (p) rx_p = v; else rx_a = v;
    repeat (16) @(posedge clk);
    #2;
  endtask

  task automatic idle(input bit p, input int n);
    for (int i = 0; i < n; i++) drive_bit(p, 1'b1);
  endtask

  task automatic send_frame(input bit p, input logic [7:0] d, input logic pb, input logic stopv);
    drive_bit(p, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(p, d[i]);
    if (p) drive_bit(p, pb);
    drive_bit(p, stopv);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (a_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", a_valid); end
    checks++; if (a_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h want=00", a_data); end
    checks++; if ({a_pe, a_fe, a_ovr, a_brk} !== 4'b0) begin failures++; $display("FAIL reset_flags got=%b want=0000", {a_pe, a_fe, a_ovr, a_brk}); end
    checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", a_busy); end
    checks++; if ({p_valid, p_pe, p_fe} !== 3'b0) begin failures++; $display("FAIL reset_par_inst got=%b want=000", {p_valid, p_pe, p_fe}); end
    @(posedge clk); #2;
    rst_n = 1'b1;
    idle(0, 2);
    checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL idle_busy got=%b want=0", a_busy); end
  endtask

  task automatic test_basic();
    int n0 = got_a.size();
    int o0 = ovr_a;
    send_frame(0, 8'h55, 1'b0, 1'b1);
    send_frame(0, 8'hA3, 1'b0, 1'b1);
    idle(0, 2);
    checks++; if (got_a.size() - n0 !== 2) begin failures++; $display("FAIL basic_count got=%0d want=2", got_a.size() - n0); end
    else begin
      checks++; if (got_a[n0] !== {2'b00, 8'h55}) begin failures++; $display("FAIL basic_w0 got=%h want=%h", got_a[n0], {2'b00, 8'h55}); end
      checks++; if (got_a[n0+1] !== {2'b00, 8'hA3}) begin failures++; $display("FAIL basic_w1 got=%h want=%h", got_a[n0+1], {2'b00, 8'hA3}); end
    end
    checks++; if (ovr_a - o0 !== 0) begin failures++; $display("FAIL basic_overrun got=%0d want=0", ovr_a - o0); end
  endtask

  task automatic test_parity();
    int n0 = got_p.size();
    send_frame(1, 8'hA3, 1'b1, 1'b1);
    idle(1, 1);
    send_frame(1, 8'hA3, 1'b0, 1'b1);
    idle(1, 2);
    checks++; if (got_p.size() - n0 !== 2) begin failures++; $display("FAIL parity_count got=%0d want=2", got_p.size() - n0); end
    else begin
      checks++; if (got_p[n0] !== {2'b10, 8'hA3}) begin failures++; $display("FAIL parity_bad got=%h want=%h", got_p[n0], {2'b10, 8'hA3}); end
      checks++; if (got_p[n0+1] !== {2'b00, 8'hA3}) begin failures++; $display("FAIL parity_good got=%h want=%h", got_p[n0+1], {2'b00, 8'hA3}); end
    end
  endtask

  task automatic test_frame_err();
    int n0 = got_a.size();
    int b0 = brk_a;
    send_frame(0, 8'h3C, 1'b0, 1'b0);
    idle(0, 2);
    checks++; if (got_a.size() - n0 !== 1) begin failures++; $display("FAIL ferr_count got=%0d want=1", got_a.size() - n0); end
    else begin
      checks++; if (got_a[n0] !== {2'b01, 8'h3C}) begin failures++; $display("FAIL ferr_word got=%h want=%h", got_a[n0], {2'b01, 8'h3C}); end
    end
    checks++; if (brk_a - b0 !== 0) begin failures++; $display("FAIL ferr_break got=%0d want=0", brk_a - b0); end
  endtask

  task automatic test_overrun();
    int n0 = got_a.size();
    int o0 = ovr_a;
    rdy_a = 1'b0;
    send_frame(0, 8'h11, 1'b0, 1'b1);
    send_frame(0, 8'h22, 1'b0, 1'b1);
    idle(0, 1);
    checks++; if (ovr_a - o0 !== 1) begin failures++; $display("FAIL ovr_pulses got=%0d want=1", ovr_a - o0); end
    checks++; if ({a_valid, a_data} !== {1'b1, 8'h11}) begin failures++; $display("FAIL ovr_held got=%b/%h want=1/11", a_valid, a_data); end
    rdy_a = 1'b1;
    idle(0, 2);
    checks++; if (got_a.size() - n0 !== 1) begin failures++; $display("FAIL ovr_count got=%0d want=1", got_a.size() - n0); end
    else begin
      checks++; if (got_a[n0] !== {2'b00, 8'h11}) begin failures++; $display("FAIL ovr_word got=%h want=%h", got_a[n0], {2'b00, 8'h11}); end
    end
  endtask

  task automatic test_break();
    int n0 = got_a.size();
    int b0 = brk_a;
    rx_a = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    idle(0, 2);
    checks++; if (got_a.size() - n0 !== 0 || brk_a - b0 !== 0) begin failures++; $display("FAIL glitch got words=%0d breaks=%0d want 0/0", got_a.size() - n0, brk_a - b0); end
    for (int i = 0; i < 12; i++) drive_bit(0, 1'b0);
    idle(0, 2);
    checks++; if (brk_a - b0 !== 1) begin failures++; $display("FAIL break_pulses got=%0d want=1", brk_a - b0); end
    checks++; if (got_a.size() - n0 !== 0) begin failures++; $display("FAIL break_words got=%0d want=0", got_a.size() - n0); end
    send_frame(0, 8'h5A, 1'b0, 1'b1);
    idle(0, 2);
    checks++; if (got_a.size() - n0 !== 1) begin failures++; $display("FAIL postbrk_count got=%0d want=1", got_a.size() - n0); end
    else begin
      checks++; if (got_a[n0] !== {2'b00, 8'h5A}) begin failures++; $display("FAIL postbrk_word got=%h want=%h", got_a[n0], {2'b00, 8'h5A}); end
    end
  endtask

  task automatic test_reset_mid();
    int n0;
    int b0 = brk_a;
    logic [7:0] d = 8'h55;
    rdy_a = 1'b0;
    send_frame(0, 8'h77, 1'b0, 1'b1);
    idle(0, 1);
    checks++; if ({a_valid, a_data} !== {1'b1, 8'h77}) begin failures++; $display("FAIL rmid_pre got=%b/%h want=1/77", a_valid, a_data); end
    n0 = got_a.size();
    drive_bit(0, 1'b0);
    for (int i = 0; i < 3; i++) drive_bit(0, d[i]);
    rx_a = d[3];
    repeat (8) @(posedge clk);
    #2;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if ({a_valid, a_data, a_pe, a_fe, a_busy} !== 12'h000) begin failures++; $display("FAIL rmid_outputs got=%b/%h/%b%b%b want=0/00/000", a_valid, a_data, a_pe, a_fe, a_busy); end
    repeat (7) @(posedge clk);
    #2;
    for (int i = 4; i < 7; i++) drive_bit(0, d[i]);
    rx_a = d[7];
    repeat (8) @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #2;
    drive_bit(0, 1'b1);
    idle(0, 2);
    rdy_a = 1'b1;
    send_frame(0, 8'h5A, 1'b0, 1'b1);
    idle(0, 2);
    checks++; if (got_a.size() - n0 !== 1) begin failures++; $display("FAIL rmid_count got=%0d want=1", got_a.size() - n0); end
    else begin
      checks++; if (got_a[n0] !== {2'b00, 8'h5A}) begin failures++; $display("FAIL rmid_word got=%h want=%h", got_a[n0], {2'b00, 8'h5A}); end
    end
    checks++; if (brk_a - b0 !== 0) begin failures++; $display("FAIL rmid_break got=%0d want=0", brk_a - b0); end
  endtask

  task automatic test_random();
    logic [9:0] exp_a[$];
    logic [9:0] exp_p[$];
    int n0 = got_a.size();
    int m0 = got_p.size();
    int b0 = brk_a;
    int exp_brk = 0;
    logic [7:0] d;
    logic stopv, pb, flip, perr;
    for (int i = 0; i < 24; i++) begin
      d = 8'($urandom_range(0, 255));
      stopv = ($urandom_range(0, 3) != 0);
      if (i % 8 == 3) begin d = 8'h00; stopv = 1'b0; end
      send_frame(0, d, 1'b0, stopv);
      if (d == 8'h00 && !stopv) exp_brk++;
      else exp_a.push_back({1'b0, ~stopv, d});
      idle(0, stopv ? int'($urandom_range(0, 2)) : 1 + int'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 12; i++) begin
      d = 8'($urandom_range(0, 255));
      flip = $urandom_range(0, 1) != 0;
      pb = (($countones(d) % 2) != 0) ^ flip;
      perr = ($countones({pb, d}) % 2) != 0;
      send_frame(1, d, pb, 1'b1);
      exp_p.push_back({perr, 1'b0, d});
      idle(1, int'($urandom_range(0, 2)));
    end
    idle(0, 2);
    checks++; if (brk_a - b0 !== exp_brk) begin failures++; $display("FAIL rand_breaks got=%0d want=%0d", brk_a - b0, exp_brk); end
    checks++; if (got_a.size() - n0 !== exp_a.size()) begin failures++; $display("FAIL rand_a_count got=%0d want=%0d", got_a.size() - n0, exp_a.size()); end
    else begin
      for (int i = 0; i < exp_a.size(); i++) begin
        checks++; if (got_a[n0+i] !== exp_a[i]) begin failures++; $display("FAIL rand_a_word[%0d] got=%h want=%h", i, got_a[n0+i], exp_a[i]); end
      end
    end
    checks++; if (got_p.size() - m0 !== exp_p.size()) begin failures++; $display("FAIL rand_p_count got=%0d want=%0d", got_p.size() - m0, exp_p.size()); end
    else begin
      for (int i = 0; i < exp_p.size(); i++) begin
        checks++; if (got_p[m0+i] !== exp_p[i]) begin failures++; $display("FAIL rand_p_word[%0d] got=%h want=%h", i, got_p[m0+i], exp_p[i]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_frame_err();
    test_overrun();
    test_break();
    test_reset_mid();
    test_random();
    checks++; if (ovr_p !== 0 || brk_p !== 0) begin failures++; $display("FAIL par_inst_pulses got ovr=%0d brk=%0d want 0/0", ovr_p, brk_p); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
